// File: rtl/wb_snoop_responder.sv
// Snoop responder: turns arbiter READ snoops into dcache lookups and returns the
// registered result, keeping saturating hit/miss statistics.
module wb_snoop_responder #(
  parameter int dw    = 32,
  parameter int aw    = 32,
  parameter int cnt_w = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [aw-1:0]    snoop_adr_i,
  input  logic             snoop_type_i,
  output logic             snoop_ack_o,
  output logic             snoop_hit_o,
  output logic [dw-1:0]    snoop_dat_o,
  output logic             lkp_req_o,
  output logic [aw-1:0]    lkp_adr_o,
  input  logic             lkp_gnt_i,
  input  logic             lkp_valid_i,
  input  logic             lkp_hit_i,
  input  logic [dw-1:0]    lkp_dat_i,
  output logic [cnt_w-1:0] hit_cnt_o,
  output logic [cnt_w-1:0] miss_cnt_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]       state;
  logic [aw-1:0]    adr;
  logic             ack;
  logic             hit;
  logic [dw-1:0]    dat;
  logic             stale;
  logic [cnt_w-1:0] hit_cnt;
  logic [cnt_w-1:0] miss_cnt;

  // stale marks a lookup that was granted but abandoned; its result pulse is still in flight
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      adr      <= '0;
      ack      <= 1'b0;
      hit      <= 1'b0;
      dat      <= '0;
      stale    <= 1'b0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lkp_valid_i) stale <= 1'b0;
          if (snoop_type_i) begin
            adr   <= snoop_adr_i;
            state <= REQ;
          end
        end
        REQ: begin
          if (!snoop_type_i) begin
            state <= IDLE;
            if (lkp_gnt_i) stale <= 1'b1;
            else if (lkp_valid_i) stale <= 1'b0;
          end else begin
            if (lkp_valid_i) stale <= 1'b0;
            if (lkp_gnt_i) state <= WAIT;
          end
        end
        WAIT: begin
          if (!snoop_type_i) begin
            // a pulse arriving now answers the older lookup if one was already stale
            state <= IDLE;
            stale <= stale | ~lkp_valid_i;
          end else if (lkp_valid_i) begin
            if (stale) begin
              stale <= 1'b0;
            end else begin
              state <= RESP;
              ack   <= 1'b1;
              hit   <= lkp_hit_i;
              dat   <= lkp_hit_i ? lkp_dat_i : '0;
              if (lkp_hit_i) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + cnt_w'(1);
              end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + cnt_w'(1);
              end
            end
          end
        end
        RESP: begin
          if (lkp_valid_i) stale <= 1'b0;
          if (!snoop_type_i) begin
            state <= IDLE;
            ack   <= 1'b0;
            hit   <= 1'b0;
            dat   <= '0;
          end else if (snoop_adr_i != adr) begin
            state <= REQ;
            adr   <= snoop_adr_i;
            ack   <= 1'b0;
            hit   <= 1'b0;
            dat   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign snoop_ack_o = ack;
  assign snoop_hit_o = hit;
  assign snoop_dat_o = dat;
  assign lkp_req_o   = (state == REQ);
  assign lkp_adr_o   = adr;
  assign hit_cnt_o   = hit_cnt;
  assign miss_cnt_o  = miss_cnt;

endmodule

// File: tb/tb_wb_snoop_responder.sv
// Directed bench for wb_snoop_responder; counters built 2 bits wide so saturation is reachable.
module tb_wb_snoop_responder;

  localparam int dw    = 32;
  localparam int aw    = 32;
  localparam int cnt_w = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [aw-1:0]    snoop_adr;
  logic             snoop_type;
  logic             snoop_ack;
  logic             snoop_hit;
  logic [dw-1:0]    snoop_dat;
  logic             lkp_req;
  logic [aw-1:0]    lkp_adr;
  logic             lkp_gnt;
  logic             lkp_valid;
  logic             lkp_hit;
  logic [dw-1:0]    lkp_dat;
  logic [cnt_w-1:0] hit_cnt;
  logic [cnt_w-1:0] miss_cnt;

  int checks   = 0;
  int failures = 0;
  int req_cycles;

  wb_snoop_responder #(.dw(dw), .aw(aw), .cnt_w(cnt_w)) dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .snoop_adr_i  (snoop_adr),
    .snoop_type_i (snoop_type),
    .snoop_ack_o  (snoop_ack),
    .snoop_hit_o  (snoop_hit),
    .snoop_dat_o  (snoop_dat),
    .lkp_req_o    (lkp_req),
    .lkp_adr_o    (lkp_adr),
    .lkp_gnt_i    (lkp_gnt),
    .lkp_valid_i  (lkp_valid),
    .lkp_hit_i    (lkp_hit),
    .lkp_dat_i    (lkp_dat),
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full hit transaction from IDLE back to IDLE, checking the held response
  task automatic apply_hit(input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_cnt);
    snoop_adr = a; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    tick();
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = d;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("sat_ack", 32'(snoop_ack), 32'd1);
    check_output("sat_dat", snoop_dat, d);
    check_output("sat_hit_cnt", 32'(hit_cnt), exp_cnt);
    snoop_type = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; snoop_adr = '0; snoop_type = 1'b0;
    lkp_gnt = 1'b0; lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    tick();
    tick();
    check_output("rst_ack", 32'(snoop_ack), 32'd0);
    check_output("rst_req", 32'(lkp_req), 32'd0);
    check_output("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check_output("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Hit at 0x100 with immediate grant
    snoop_adr = 32'h100; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    check_output("hit_req", 32'(lkp_req), 32'd1);
    check_output("hit_lkp_adr", lkp_adr, 32'h100);
    check_output("hit_ack_early", 32'(snoop_ack), 32'd0);
    tick();
    check_output("hit_req_wait", 32'(lkp_req), 32'd0);
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = 32'hDEADBEEF;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("hit_ack", 32'(snoop_ack), 32'd1);
    check_output("hit_hit", 32'(snoop_hit), 32'd1);
    check_output("hit_dat", snoop_dat, 32'hDEADBEEF);
    check_output("hit_cnt1", 32'(hit_cnt), 32'd1);
    tick();
    check_output("hit_ack_held", 32'(snoop_ack), 32'd1);
    check_output("hit_dat_held", snoop_dat, 32'hDEADBEEF);
    snoop_type = 1'b0;
    tick();
    check_output("hit_ack_clr", 32'(snoop_ack), 32'd0);
    check_output("hit_hit_clr", 32'(snoop_hit), 32'd0);
    check_output("hit_dat_clr", snoop_dat, 32'h0);

    // Miss with grant withheld for three request cycles
    snoop_adr = 32'h300; snoop_type = 1'b1;
    tick();
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      if (lkp_req) req_cycles++;
      if (i == 3) lkp_gnt = 1'b1;
      tick();
    end
    check_output("miss_req_cycles", 32'(req_cycles), 32'd4);
    check_output("miss_req_low", 32'(lkp_req), 32'd0);
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b0; lkp_dat = 32'h0000ABCD;
    tick();
    lkp_valid = 1'b0; lkp_dat = '0;
    check_output("miss_ack", 32'(snoop_ack), 32'd1);
    check_output("miss_hit", 32'(snoop_hit), 32'd0);
    check_output("miss_dat", snoop_dat, 32'h0);
    check_output("miss_cnt1", 32'(miss_cnt), 32'd1);
    check_output("miss_hit_cnt", 32'(hit_cnt), 32'd1);
    snoop_type = 1'b0;
    tick();

    // Abort from WAIT; the late pulse must not answer the next snoop
    snoop_adr = 32'h400; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    tick();
    snoop_type = 1'b0; lkp_gnt = 1'b0;
    tick();
    check_output("abort_req", 32'(lkp_req), 32'd0);
    snoop_adr = 32'h200; snoop_type = 1'b1;
    tick();
    check_output("abort_new_adr", lkp_adr, 32'h200);
    lkp_gnt = 1'b1;
    tick();
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = 32'h11;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("abort_stale_ack", 32'(snoop_ack), 32'd0);
    check_output("abort_stale_hit_cnt", 32'(hit_cnt), 32'd1);
    tick();
    lkp_valid = 1'b1; lkp_hit = 1'b0;
    tick();
    lkp_valid = 1'b0;
    check_output("abort_ack", 32'(snoop_ack), 32'd1);
    check_output("abort_hit", 32'(snoop_hit), 32'd0);
    check_output("abort_miss_cnt", 32'(miss_cnt), 32'd2);
    snoop_type = 1'b0;
    tick();

    // Address change while responding restarts the lookup
    snoop_adr = 32'h100; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    tick();
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = 32'hCAFE0001;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("chg_ack", 32'(snoop_ack), 32'd1);
    snoop_adr = 32'h104;
    tick();
    check_output("chg_ack_drop", 32'(snoop_ack), 32'd0);
    check_output("chg_dat_drop", snoop_dat, 32'h0);
    check_output("chg_req", 32'(lkp_req), 32'd1);
    check_output("chg_lkp_adr", lkp_adr, 32'h104);
    lkp_gnt = 1'b1;
    tick();
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = 32'hCAFE0002;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("chg_dat_new", snoop_dat, 32'hCAFE0002);
    check_output("chg_hit_cnt", 32'(hit_cnt), 32'd3);
    snoop_type = 1'b0;
    tick();

    // Abort in REQ coinciding with grant still leaves a stale pulse to discard
    snoop_adr = 32'h700; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    snoop_type = 1'b0;
    tick();
    lkp_gnt = 1'b0; snoop_adr = 32'h710; snoop_type = 1'b1;
    tick();
    lkp_gnt = 1'b1;
    tick();
    lkp_gnt = 1'b0; lkp_valid = 1'b1; lkp_hit = 1'b1; lkp_dat = 32'h22;
    tick();
    check_output("reqabort_stale_ack", 32'(snoop_ack), 32'd0);
    lkp_dat = 32'h33;
    tick();
    lkp_valid = 1'b0; lkp_hit = 1'b0; lkp_dat = '0;
    check_output("reqabort_ack", 32'(snoop_ack), 32'd1);
    check_output("reqabort_dat", snoop_dat, 32'h33);
    snoop_type = 1'b0;
    tick();

    // Hit counter stays pinned at all-ones
    apply_hit(32'h800, 32'h44, 32'd3);
    apply_hit(32'h804, 32'h55, 32'd3);
    check_output("sat_miss_cnt", 32'(miss_cnt), 32'd2);

    // Asynchronous reset while waiting for a result
    snoop_adr = 32'h500; snoop_type = 1'b1; lkp_gnt = 1'b1;
    tick();
    tick();
    lkp_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_output("areset_ack", 32'(snoop_ack), 32'd0);
    check_output("areset_req", 32'(lkp_req), 32'd0);
    check_output("areset_adr", lkp_adr, 32'h0);
    check_output("areset_hit_cnt", 32'(hit_cnt), 32'd0);
    check_output("areset_miss_cnt", 32'(miss_cnt), 32'd0);
    snoop_adr = 32'h600;
    tick();
    rst = 1'b0;
    tick();
    check_output("areset_restart_req", 32'(lkp_req), 32'd1);
    check_output("areset_restart_adr", lkp_adr, 32'h600);
    snoop_type = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_snoop_responder.md
WB_SNOOP_RESPONDER -- requirements
Module: wb_snoop_responder

Interface
REQ-001 Parameter dw, 32, data width of snooped word.
REQ-002 Parameter aw, 32, address width.
REQ-003 Parameter cnt_w, 16, width of hit/miss statistics counters.
REQ-004 wb_clk_i  in  1  sole clock; all state on rising edge.
REQ-005 wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 snoop_adr_i  in  aw  snoop address from arbiter.
REQ-007 snoop_type_i  in  1  1=READ snoop requested, 0=IDLE.
REQ-008 snoop_ack_o  out  1  response valid, registered.
REQ-009 snoop_hit_o  out  1  line present in local dcache, qualified by ack.
REQ-010 snoop_dat_o  out  dw  snooped word, qualified by ack&hit, else 0.
REQ-011 lkp_req_o  out  1  lookup request to dcache snoop port.
REQ-012 lkp_adr_o  out  aw  lookup address, equals latched snoop address.
REQ-013 lkp_gnt_i  in  1  dcache accepts lookup this cycle (req&gnt = handshake).
REQ-014 lkp_valid_i  in  1  lookup result valid, one-cycle pulse, >=1 cycle after handshake.
REQ-015 lkp_hit_i  in  1  lookup hit, qualified by lkp_valid_i.
REQ-016 lkp_dat_i  in  dw  lookup data, qualified by lkp_valid_i&lkp_hit_i.
REQ-017 hit_cnt_o  out  cnt_w  number of completed snoops that hit.
REQ-018 miss_cnt_o  out  cnt_w  number of completed snoops that missed.

Function
REQ-019 FSM states IDLE, REQ, WAIT, RESP; encoding implementer's choice.
REQ-020 IDLE: snoop_type_i=1 at edge -> latch snoop_adr_i into adr register, go REQ.
REQ-021 REQ: lkp_req_o=1, lkp_adr_o=adr register; edge with lkp_gnt_i=1 -> WAIT.
REQ-022 WAIT: lkp_req_o=0; edge with lkp_valid_i=1 -> register ack=1, hit=lkp_hit_i, dat=(lkp_hit_i ? lkp_dat_i : 0), go RESP.
REQ-023 RESP: ack/hit/dat held constant while snoop_type_i=1 and snoop_adr_i equals adr register.
REQ-024 RESP, snoop_type_i=0 at edge -> ack, hit, dat cleared to 0, go IDLE.
REQ-025 RESP, snoop_type_i=1 and snoop_adr_i != adr register -> clear ack/hit/dat, latch new address, go REQ (new snoop).
REQ-026 REQ or WAIT, snoop_type_i=0 at edge -> abort to IDLE; no response, no counter update.
REQ-027 Abort from WAIT: next lkp_valid_i pulse (stale) SHALL be discarded; a one-bit "stale pending" flag blocks WAIT->RESP for that one pulse if a new snoop starts before it arrives.
REQ-028 Abort in REQ with simultaneous lkp_gnt_i=1 counts as handshake; stale flag set.
REQ-029 Address change in REQ/WAIT (type still 1) ignored; address only re-checked in RESP.
REQ-030 Latency: type rises edge N, gnt immediate, valid one cycle after handshake -> ack high after edge N+3.
REQ-031 snoop_ack_o, snoop_hit_o, snoop_dat_o driven only from registers; no combinational path from inputs.
REQ-032 lkp_req_o asserted only in REQ; a request once raised SHALL stay high until gnt or abort.
REQ-033 On entry to RESP, hit_cnt_o increments if hit else miss_cnt_o increments; counters saturate at all-ones.
REQ-034 lkp_valid_i in IDLE/REQ/RESP ignored (except clearing stale flag).

Reset
REQ-035 wb_rst_i=1 asynchronously forces IDLE; ack, hit, dat, lkp_req_o, stale flag, adr register, hit_cnt_o, miss_cnt_o all 0.
REQ-036 Reset mid-snoop (REQ/WAIT/RESP) discards transaction; first edge after release evaluates IDLE rules.

Verification
REQ-037 Hit: adr=0x100, type=1, gnt=1, valid next cycle hit=1 dat=0xDEADBEEF -> ack=1 hit=1 dat=0xDEADBEEF held until type=0, then all 0; hit_cnt=1.
REQ-038 Miss: type=1, gnt delayed 3 cycles, valid hit=0 -> ack=1 hit=0 dat=0, lkp_req_o high 4 cycles; miss_cnt=1.
REQ-039 Abort: type=1, handshake, type=0 before valid, new snoop adr=0x200 starts, stale valid (hit=1 dat=0x11) arrives -> ignored; later valid hit=0 -> ack=1 hit=0.
REQ-040 Address change in RESP: ack held for 0x100, adr -> 0x104 with type=1 -> ack drops next cycle, new lkp_req_o with lkp_adr_o=0x104.
REQ-041 Saturation: preload via 2^cnt_w-1 hits (or cnt_w=2 build, 5 hits) -> hit_cnt_o stays 3.
REQ-042 Async reset in WAIT between edges -> outputs 0 immediately, counters 0, FSM IDLE.
